// File: rtl/itof_share_arb.sv
// Round-robin arbiter that lets NREQ issue lanes share one combinational int-to-float
// converter, with a single-entry registered result stage toward writeback.
module itof_share_arb #(
  parameter int NREQ = 2,
  parameter int TAGW = 6,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [32*NREQ-1:0]     req_data,
  input  logic [TAGW*NREQ-1:0]   req_tag,
  output logic [NREQ-1:0]        req_ready,
  output logic [31:0]            cvt_x,
  input  logic [31:0]            cvt_y,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [31:0]            resp_data,
  output logic [TAGW-1:0]        resp_tag,
  output logic [IDW-1:0]         resp_id,
  output logic [CNTW-1:0]        conflict_cnt
);

  localparam logic EMPTY = 1'b0;
  localparam logic FULL  = 1'b1;

  logic            state;
  logic [IDW-1:0]  ptr;
  logic [IDW-1:0]  g;
  logic [TAGW-1:0] g_tag;
  logic            any;
  logic            accept;
  logic            xfer;
  logic            multi;
  int unsigned     idx;

  assign resp_valid = (state == FULL);
  assign accept     = (state == EMPTY) | resp_ready;
  assign multi      = ($countones(req_valid) > 1);

  // Scan lanes starting at ptr with wrap; the first valid lane wins.
  always_comb begin
    any   = 1'b0;
    g     = '0;
    g_tag = '0;
    cvt_x = '0;
    idx   = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= 32'(NREQ)) idx = idx - 32'(NREQ);
      if (!any && req_valid[idx]) begin
        any   = 1'b1;
        g     = IDW'(idx);
        cvt_x = req_data[32*idx +: 32];
        g_tag = req_tag[TAGW*idx +: TAGW];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (any) req_ready[g] = accept;
    xfer = any & accept;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= EMPTY;
      ptr          <= '0;
      resp_data    <= '0;
      resp_tag     <= '0;
      resp_id      <= '0;
      conflict_cnt <= '0;
    end else begin
      if (xfer) begin
        state     <= FULL;
        resp_data <= cvt_y;
        resp_tag  <= g_tag;
        resp_id   <= g;
        ptr       <= (g == IDW'(NREQ - 1)) ? '0 : g + 1'b1;
      end else if (resp_ready) begin
        state <= EMPTY;
      end
      if (multi && conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

endmodule
